usb_fe_tx: RTL
==============

USB_FE_TX -- requirements
Module: usb_fe_tx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 4, meaning clk cycles per USB FS bit time (48 MHz clk, 12 Mb/s line).
REQ-002 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tx_data  input  8  packet byte (PID first), sent LSB first.
REQ-005 SHALL have port tx_last  input  1  tx_data is the final byte of the packet.
REQ-006 SHALL have port tx_valid  input  1  tx_data/tx_last valid.
REQ-007 SHALL have port tx_ready  output  1  one-byte holding buffer empty; byte accepted on the edge where tx_valid && tx_ready.
REQ-008 SHALL have port dp_tx  output  1  D+ drive value.
REQ-009 SHALL have port dn_tx  output  1  D- drive value.
REQ-010 SHALL have port tx_oe  output  1  line output enable to usb_fe_if; 0 = release line (Z).
REQ-011 SHALL have port busy  output  1  state is not IDLE.
REQ-012 SHALL have port tx_underrun  output  1  one-cycle pulse on buffer underrun.

Function
REQ-013 SHALL use states IDLE, SYNC, DATA, EOP and, with macro, IPD; every line change occurs on a bit strobe, each line value held exactly CLK_PER_BIT cycles.
REQ-014 SHALL register tx_ready = buffer empty; shifter loads the buffer at a byte boundary, so accept and load never coincide.
REQ-015 SHALL move IDLE->SYNC on the edge after the buffer becomes full, asserting tx_oe and driving the first K on that same edge.
REQ-016 SHALL drive SYNC as K J K J K J K K, then move to DATA loading the buffered byte.
REQ-017 SHALL NRZI-encode: data 0 toggles line J<->K, data 1 holds; J = dp 1/dn 0, K = dp 0/dn 1.
REQ-018 SHALL count consecutive 1s starting at 1 after SYNC; after the sixth 1 insert one toggle (stuff) bit and clear the count; any 0 clears the count.
REQ-019 SHALL send a pending stuff bit even when the sixth 1 is the final data bit, before EOP.
REQ-020 SHALL, at a byte boundary after a byte with tx_last=0, load the next buffered byte without gap; if the buffer is empty, pulse tx_underrun and enter EOP immediately.
REQ-021 SHALL, after the final byte (plus stuff bit), drive EOP as SE0, SE0, J, then deassert tx_oe and leave state EOP.
REQ-022 SHALL accept bytes for the next packet in any state; a byte accepted during EOP/IPD waits in the buffer.
REQ-023 SHALL hold dp_tx=1, dn_tx=0 (J) whenever tx_oe=0.

Reset
REQ-024 SHALL on rst, immediately and mid-packet included: state IDLE, buffer empty, tx_oe=0, dp_tx=1, dn_tx=0, busy=0, tx_underrun=0, tx_ready=0.
REQ-025 SHALL set tx_ready=1 on the first clk edge after rst deasserts.

Configuration
REQ-026 SHALL, with USB_FE_TX_IPD_EN defined, go EOP->IPD and stay there 6 bit times (6*CLK_PER_BIT cycles, busy=1, tx_oe=0) before IDLE.
REQ-027 SHALL, without USB_FE_TX_IPD_EN, go EOP->IDLE directly; IPD state absent.

Verification
REQ-028 SHALL cover ACK: one byte 0xD2, tx_last=1 -> line KJKJKJKK JJKJJKKK SE0 SE0 J, tx_oe high exactly 76 cycles (CLK_PER_BIT=4).
REQ-029 SHALL cover stuffing: bytes 0xC3, 0xFF, 0xFF(last) -> 3 stuff bits, last one after final data bit, tx_oe high 152 cycles.
REQ-030 SHALL cover underrun: 0xC3 (tx_last=0), then tx_valid low -> tx_underrun one pulse at first byte boundary, EOP follows, tx_oe high 76 cycles.
REQ-031 SHALL cover reset mid-DATA: rst asserted in byte 2 -> tx_oe=0, dp/dn=1/0 without waiting for clk; tx_ready=1 one edge after release.
REQ-032 SHALL cover back-to-back: second packet first byte offered during EOP -> next SYNC begins 1 cycle after EOP J ends (no macro) or 24 cycles later (USB_FE_TX_IPD_EN).

Source files
------------

// File: rtl/usb_fe_tx.sv
// USB full-speed transmit front end: SYNC, NRZI with bit stuffing, EOP, one-byte holding buffer.
// Optional inter-packet delay state is compiled in with `define USB_FE_TX_IPD_EN.
module usb_fe_tx #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dp_tx,
    output logic       dn_tx,
    output logic       tx_oe,
    output logic       busy,
    output logic       tx_underrun
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

`ifdef USB_FE_TX_IPD_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
        S_EOP  = 3'd3,
        S_IPD  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
        S_EOP  = 3'd3
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      ones_q, ones_d;
    logic [7:0]      shift_q, shift_d;
    logic            last_cur_q, last_cur_d;
    logic            line_q, line_d;
    logic            se0_q, se0_d;
    logic            oe_q, oe_d;
    logic [7:0]      buf_data_q, buf_data_d;
    logic            buf_last_q, buf_last_d;
    logic            buf_full_q, buf_full_d;
    logic            ready_q, ready_d;
    logic            underrun_q, underrun_d;
    logic            busy_q, busy_d;
    logic            dp_q, dp_d;
    logic            dn_q, dn_d;
    logic            strobe_s;
    logic            load_s;

    // line level after sending data bit b (line: 1 = J, 0 = K)
    function automatic logic nrzi(input logic line, input logic b);
        return b ? line : ~line;
    endfunction

    function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic b);
        return b ? (ones + 3'd1) : 3'd0;
    endfunction

    // next-state, line encoding and holding-buffer logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ones_d     = ones_q;
        shift_d    = shift_q;
        last_cur_d = last_cur_q;
        line_d     = line_q;
        se0_d      = se0_q;
        oe_d       = oe_q;
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        underrun_d = 1'b0;
        load_s     = 1'b0;
        strobe_s   = (cnt_q == CW'(CLK_PER_BIT - 1));

        if ((state_q == S_IDLE) || strobe_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    state_d = S_SYNC;
                    oe_d    = 1'b1;
                    se0_d   = 1'b0;
                    line_d  = 1'b0;
                    idx_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SYNC: begin
                if (strobe_s) begin
                    if (idx_q == 3'd7) begin
                        // SYNC ends on a 1, so the run count starts at one
                        state_d    = S_DATA;
                        load_s     = 1'b1;
                        shift_d    = buf_data_q;
                        last_cur_d = buf_last_q;
                        idx_d      = 3'd0;
                        line_d     = nrzi(line_q, buf_data_q[0]);
                        ones_d     = ones_next(3'd1, buf_data_q[0]);
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        line_d = (idx_q == 3'd6) ? line_q : ~line_q;
                    end
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_DATA: begin
                if (strobe_s) begin
                    if (ones_q == 3'd6) begin
                        line_d = ~line_q;
                        ones_d = 3'd0;
                    end else if (idx_q != 3'd7) begin
                        idx_d  = idx_q + 3'd1;
                        line_d = nrzi(line_q, shift_q[idx_q + 3'd1]);
                        ones_d = ones_next(ones_q, shift_q[idx_q + 3'd1]);
                    end else if (last_cur_q) begin
                        state_d = S_EOP;
                        se0_d   = 1'b1;
                        idx_d   = 3'd0;
                    end else if (buf_full_q) begin
                        load_s     = 1'b1;
                        shift_d    = buf_data_q;
                        last_cur_d = buf_last_q;
                        idx_d      = 3'd0;
                        line_d     = nrzi(line_q, buf_data_q[0]);
                        ones_d     = ones_next(ones_q, buf_data_q[0]);
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_EOP;
                        se0_d      = 1'b1;
                        idx_d      = 3'd0;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_EOP: begin
                if (strobe_s) begin
                    if (idx_q == 3'd0) begin
                        idx_d = 3'd1;
                    end else if (idx_q == 3'd1) begin
                        se0_d  = 1'b0;
                        line_d = 1'b1;
                        idx_d  = 3'd2;
                    end else begin
                        oe_d   = 1'b0;
                        line_d = 1'b1;
                        idx_d  = 3'd0;
`ifdef USB_FE_TX_IPD_EN
                        state_d = S_IPD;
`else
                        state_d = S_IDLE;
`endif
                    end
                end else begin
                    state_d = S_EOP;
                end
            end
`ifdef USB_FE_TX_IPD_EN
            S_IPD: begin
                if (strobe_s) begin
                    if (idx_q == 3'd5) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_IPD;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b0;
                se0_d   = 1'b0;
                line_d  = 1'b1;
                idx_d   = 3'd0;
            end
        endcase

        // ready is the registered empty flag, so accept and load are never in the same cycle
        if (load_s) begin
            buf_full_d = 1'b0;
        end else if (tx_valid && ready_q) begin
            buf_full_d = 1'b1;
            buf_data_d = tx_data;
            buf_last_d = tx_last;
        end else begin
            buf_full_d = buf_full_q;
        end

        ready_d = ~buf_full_d;
        busy_d  = (state_d != S_IDLE);
        dp_d    = ~oe_d | (~se0_d & line_d);
        dn_d    = oe_d & ~se0_d & ~line_d;
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            ones_q     <= 3'd0;
            shift_q    <= 8'd0;
            last_cur_q <= 1'b0;
            line_q     <= 1'b1;
            se0_q      <= 1'b0;
            oe_q       <= 1'b0;
            buf_data_q <= 8'd0;
            buf_last_q <= 1'b0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
            dp_q       <= 1'b1;
            dn_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ones_q     <= ones_d;
            shift_q    <= shift_d;
            last_cur_q <= last_cur_d;
            line_q     <= line_d;
            se0_q      <= se0_d;
            oe_q       <= oe_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            buf_full_q <= buf_full_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
            dp_q       <= dp_d;
            dn_q       <= dn_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_oe       = oe_q;
    assign dp_tx       = dp_q;
    assign dn_tx       = dn_q;
    assign busy        = busy_q;
    assign tx_underrun = underrun_q;

endmodule
